// File: rtl/fwd_hazard_ctrl_pkg.sv
// fwd_pkg: shared types and constants for the forwarding / hazard controller.
//   SEL_*        : encoding of the operand-forwarding selects seen by the EX stage
//   REG_IDX_W    : architectural register index width
//   stage_rec_t  : shadow record of one in-flight instruction (EX, MEM or WB)
package fwd_pkg;

  localparam int unsigned REG_IDX_W = 5;

  localparam logic [1:0] SEL_RF   = 2'b00;  // register-file data, no forward
  localparam logic [1:0] SEL_WB   = 2'b01;  // wbResult
  localparam logic [1:0] SEL_ALU  = 2'b10;  // aluResult (EX/MEM result)
  localparam logic [1:0] SEL_ZERO = 2'b11;  // zero operand, never generated here

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 reg_write;
    logic                 mem_read;
  } stage_rec_t;

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// fwd_hazard_ctrl_if: bundle between the ID/EX pipeline logic and the forwarding controller.
//   master : pipeline side, drives the ID instruction fields, flush and hold,
//            receives selOp1/selOp2, stall_id and stall_count
//   slave  : controller side, the mirror image
interface fwd_hazard_ctrl_if #(
  parameter int unsigned XLEN_IDX = 5,
  parameter int unsigned CNT_W    = 16
);

  logic                id_valid;
  logic [XLEN_IDX-1:0] id_rs1;
  logic [XLEN_IDX-1:0] id_rs2;
  logic [XLEN_IDX-1:0] id_rd;
  logic                id_reg_write;
  logic                id_mem_read;
  logic                id_use_rs1;
  logic                id_use_rs2;
  logic                flush;
  logic                hold;
  logic [1:0]          selOp1;
  logic [1:0]          selOp2;
  logic                stall_id;
  logic [CNT_W-1:0]    stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
    output id_use_rs1, id_use_rs2, flush, hold,
    input  selOp1, selOp2, stall_id, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read,
    input  id_use_rs1, id_use_rs2, flush, hold,
    output selOp1, selOp2, stall_id, stall_count
  );

endinterface

// File: rtl/fwd_hazard_ctrl_sel_calc.sv
// fwd_sel_calc: combinational next-select for one operand.
//   i_use : operand is read from the register named by i_rs
//   i_rs  : source register index of the ID instruction
//   i_ex  : shadow record of the instruction currently in EX
//   i_mem : shadow record of the instruction currently in MEM
//   o_sel : SEL_ALU when the EX producer (non-load) matches, else SEL_WB when the
//           MEM producer matches, else SEL_RF; x0 never forwards
module fwd_sel_calc
  import fwd_pkg::*;
(
  input  logic                 i_use,
  input  logic [REG_IDX_W-1:0] i_rs,
  input  stage_rec_t           i_ex,
  input  stage_rec_t           i_mem,
  output logic [1:0]           o_sel
);

  logic w_ex_hit;
  logic w_mem_hit;

  // A load in EX has no result yet; that case is covered by the stall instead.
  assign w_ex_hit  = i_use && i_ex.valid && i_ex.reg_write && !i_ex.mem_read &&
                     (i_ex.rd == i_rs);
  assign w_mem_hit = i_mem.valid && i_mem.reg_write && (i_mem.rd == i_rs);

  always_comb begin
    o_sel = SEL_RF;
    if (i_rs != '0) begin
      if (w_ex_hit) begin
        o_sel = SEL_ALU;  // youngest producer wins
      end else if (w_mem_hit) begin
        o_sel = SEL_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding selects and load-use stall for a 5-stage pipeline.
// Sits beside the ID/EX register; keeps a shadow of the EX/MEM/WB destinations.
//   clk    : pipeline clock
//   resetn : asynchronous active-low reset
//   bus    : slave side of fwd_hazard_ctrl_if (ID fields, flush, hold in;
//            selOp1/selOp2 registered, stall_id combinational, stall_count out)
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int unsigned XLEN_IDX = 5,
  parameter int unsigned CNT_W    = 16
) (
  input logic              clk,
  input logic              resetn,
  fwd_hazard_ctrl_if.slave bus
);

  stage_rec_t          r_ex;
  stage_rec_t          r_mem;
  stage_rec_t          r_wb;
  logic [1:0]          r_sel_op1;
  logic [1:0]          r_sel_op2;
  logic [CNT_W-1:0]    r_stall_cnt;

  logic [XLEN_IDX-1:0] w_rs1;
  logic [XLEN_IDX-1:0] w_rs2;
  logic [XLEN_IDX-1:0] w_rd;
  logic                w_rs1_ld_hit;
  logic                w_rs2_ld_hit;
  logic                w_stall;
  stage_rec_t          w_id_rec;
  logic [1:0]          w_sel1_calc;
  logic [1:0]          w_sel2_calc;
  logic [1:0]          w_sel2;
  logic                w_unused_wb;

  assign w_rs1 = bus.id_rs1;
  assign w_rs2 = bus.id_rs2;
  assign w_rd  = bus.id_rd;

  // Load-use: the load in EX has no data until it leaves MEM, so the consumer waits
  // one cycle and then picks the value up from WB.
  assign w_rs1_ld_hit = bus.id_use_rs1 && (w_rs1 == r_ex.rd);
  assign w_rs2_ld_hit = bus.id_use_rs2 && (w_rs2 == r_ex.rd);
  assign w_stall      = bus.id_valid && r_ex.valid && r_ex.mem_read && (r_ex.rd != '0) &&
                        (w_rs1_ld_hit || w_rs2_ld_hit) && !bus.flush;

  // Record entering EX on the next advance; stall and flush turn it into a bubble.
  always_comb begin
    w_id_rec           = '0;
    w_id_rec.valid     = bus.id_valid && !w_stall && !bus.flush;
    w_id_rec.rd        = w_rd;
    w_id_rec.reg_write = bus.id_reg_write;
    w_id_rec.mem_read  = bus.id_mem_read;
  end

  fwd_sel_calc u_sel_op1 (
    .i_use (bus.id_use_rs1),
    .i_rs  (w_rs1),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel1_calc)
  );

  fwd_sel_calc u_sel_op2 (
    .i_use (bus.id_use_rs2),
    .i_rs  (w_rs2),
    .i_ex  (r_ex),
    .i_mem (r_mem),
    .o_sel (w_sel2_calc)
  );

  // Operand 2 carries the immediate when rs2 is not used, so it must never forward.
  assign w_sel2 = bus.id_use_rs2 ? w_sel2_calc : SEL_RF;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_sel_op1   <= SEL_RF;
      r_sel_op2   <= SEL_RF;
      r_stall_cnt <= '0;
    end else if (!bus.hold) begin
      r_wb      <= r_mem;
      r_mem     <= r_ex;
      r_ex      <= w_id_rec;
      r_sel_op1 <= w_id_rec.valid ? w_sel1_calc : SEL_RF;
      r_sel_op2 <= w_id_rec.valid ? w_sel2 : SEL_RF;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  // The WB record completes the shadow pipeline; the register file covers WB producers,
  // so no select reads it.
  assign w_unused_wb = ^r_wb;

  assign bus.selOp1      = r_sel_op1;
  assign bus.selOp2      = r_sel_op2;
  assign bus.stall_id    = w_stall;
  assign bus.stall_count = r_stall_cnt;

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Produces the operand-forwarding selects (selOp1, selOp2) that the execute stage consumes.
- Detects load-use hazards and stalls the front end.
- Keeps its own shadow of the in-flight destination registers for the EX, MEM and WB stages.
- Sits beside the ID/EX pipeline register. Selects are registered so they arrive aligned with the instruction entering EX.

Parameters:
- XLEN_IDX, 5, register index width (32 architectural registers).
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  source register 1 of the ID instruction
- id_rs2  in  5  source register 2 of the ID instruction
- id_rd  in  5  destination of the ID instruction
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- id_use_rs1  in  1  operand 1 comes from rs1
- id_use_rs2  in  1  operand 2 comes from rs2 (ALUSrc selects rs2)
- flush  in  1  branch/jump redirect; kill ID and EX
- hold  in  1  global freeze (memory stall); no stage advances
- selOp1  out  2  forwarding select for operand 1, valid while the instruction is in EX
- selOp2  out  2  forwarding select for operand 2, valid while the instruction is in EX
- stall_id  out  1  hold PC/IF-ID and insert a bubble into EX
- stall_count  out  CNT_W  saturating count of load-use stall cycles

Behaviour:
- Select encoding, fixed:
  - 00 = register-file data (no forward)
  - 01 = wbResult
  - 10 = aluResult (EX/MEM result)
  - 11 = zero, never generated
- Shadow records: ex_r, mem_r, wb_r. Each record is {valid, rd, reg_write, mem_read}.
- Advance on clk when hold=0:
  - wb_r<=mem_r
  - mem_r<=ex_r
  - ex_r<=ID record
  - The ID record is forced invalid when stall_id=1, flush=1 or id_valid=0.
- Load-use hazard, combinational:
  - stall_id = id_valid & ex_r.valid & ex_r.mem_read & (ex_r.rd!=0) & ((id_use_rs1 & id_rs1==ex_r.rd) | (id_use_rs2 & id_rs2==ex_r.rd)).
  - stall_id is gated to 0 when flush=1.
  - A stall lasts exactly one cycle: the load then moves to MEM and the consumer forwards from WB the following cycle.
- Next-select for operand 1:
  - 10 if id_use_rs1, ex_r.valid, ex_r.reg_write, not a load, ex_r.rd==id_rs1 and id_rs1!=0.
  - else 01 if mem_r.valid, mem_r.reg_write, mem_r.rd==id_rs1 and id_rs1!=0.
  - else 00.
  - The EX producer has priority over MEM (youngest wins).
  - Loads in MEM forward via 01.
- Operand 2 is computed identically using id_rs2/id_use_rs2. When id_use_rs2=0 the select is 00, because the immediate must pass.
- Register selOp1/selOp2 on advance. When the ID record is forced invalid (bubble or flush), the registered selects are 00.
- hold=1:
  - All records, selects and stall_count keep their values.
  - stall_id is still computed from the current state.
- Simultaneous flush and stall: flush wins; stall_id=0 and the EX bubble is inserted.
- x0 is never forwarded and never causes a stall.
- stall_count increments by 1 on every clk edge with stall_id=1 and hold=0, and saturates at all-ones.
- Reset (resetn=0, async):
  - all records invalid
  - selOp1=selOp2=00
  - stall_count=0
  - stall_id evaluates to 0 because the records are invalid
- Reset mid-operation discards all in-flight state immediately.
- Latency: selects reach EX 1 cycle after ID evaluation. stall_id is same-cycle.

Decomposition:
- Package fwd_pkg holds:
  - constants SEL_RF=2'b00, SEL_WB=2'b01, SEL_ALU=2'b10, SEL_ZERO=2'b11
  - a typedef struct for the stage record
- One natural sub-module, fwd_sel_calc: a purely combinational select for one operand, instantiated twice.

Test Plan:
- Back-to-back dependency:
  - Stimulus: add x5 in ID, then sub x6,x5,x1 next cycle.
  - Response: selOp1=10 in the sub's EX cycle and selOp2=00.
- Distance-two dependency:
  - Stimulus: writer of x7, one unrelated instruction, then a reader of x7 in rs2 with id_use_rs2=1.
  - Response: selOp2=01.
- Load-use:
  - Stimulus: lw x3 followed by add x4,x3,x2.
  - Response: stall_id=1 for exactly one cycle and a bubble in EX; then selOp1=01; stall_count=1.
- x0 and immediate:
  - Stimulus: writer of x0, then a reader of x0; also an addi whose rs2 field matches a pending rd with id_use_rs2=0.
  - Response: both selects 00 and no stall.
- Double producer:
  - Stimulus: x9 written in two consecutive instructions, then a reader.
  - Response: selOp1=10, the younger producer.
- Flush/hold/reset:
  - flush in the same cycle as a load-use condition gives stall_id=0 and selects 00 next cycle.
  - hold=1 for 3 cycles freezes the selects.
  - resetn low mid-stream clears the selects to 00 and stall_count to 0 asynchronously.
